// File: rtl/riscv_timer_slave.sv
// Memory-mapped timer slave: CTRL/COUNT/COMPARE/STATUS window behind a fixed-latency
// request/ready handshake, with a registered compare-match interrupt acknowledged by irq_ret_i.
module riscv_timer_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        mem_ready_o,
  output logic        irq_req_o,
  input  logic        irq_ret_i
);

  localparam logic [3:0]  LAT       = 4'(LATENCY);
  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pending_q, pending_d;
  logic [15:0] presc_q, presc_d;
  logic        irq_q, irq_d;

  logic        in_win;
  logic [1:0]  sel;
  logic        commit;
  logic        tick;
  logic        match;
  logic        w1c;
  logic [1:0]  unused_addr_lsb;

  assign unused_addr_lsb = mem_addr_i[1:0];

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          we_d   = mem_we_i;
          be_d   = mem_be_i;
          addr_d = mem_addr_i[31:2];
          wd_d   = mem_wd_i;
          if (LAT == 4'd0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            wait_d  = LAT - 4'd1;
          end
        end
      end
      WAIT: begin
        if (wait_q == 4'd0) state_d = RESP;
        else                wait_d  = wait_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_win      = (addr_q[31:4] == BASE_ADDR[31:4]);
  assign sel         = addr_q[3:2];
  assign commit      = (state_q == RESP) && we_q && in_win;
  assign mem_ready_o = (state_q == RESP);
  assign irq_req_o   = irq_q;

  always_comb begin
    mem_rd_o = 32'd0;
    if ((state_q == RESP) && in_win) begin
      case (sel)
        2'd0:    mem_rd_o = {29'd0, ctrl_q};
        2'd1:    mem_rd_o = count_q;
        2'd2:    mem_rd_o = compare_q;
        default: mem_rd_o = {31'd0, pending_q};
      endcase
    end
  end

  // A match is only evaluated on an increment tick, never while the timer is stopped.
  assign tick  = ctrl_q[0] && (presc_q == PRESC_MAX);
  assign match = tick && (count_q == compare_q);
  assign w1c   = commit && (sel == 2'd3) && be_q[0] && wd_q[0];

  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    ctrl_d    = ctrl_q;
    compare_d = compare_q;
    pending_d = pending_q;
    irq_d     = pending_q & ctrl_q[2];

    if (ctrl_q[0]) presc_d = tick ? 16'd0 : presc_q + 16'd1;
    if (tick)      count_d = (match && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;

    if (commit) begin
      case (sel)
        2'd0:    if (be_q[0]) ctrl_d = wd_q[2:0];
        2'd1:    if (be_q != 4'd0) count_d = byte_merge(count_q, wd_q, be_q);
        2'd2:    compare_d = byte_merge(compare_q, wd_q, be_q);
        default: ;
      endcase
    end

    // Set has priority over either clear source.
    if (irq_ret_i || w1c) pending_d = 1'b0;
    if (match)            pending_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wait_q    <= 4'd0;
      we_q      <= 1'b0;
      be_q      <= 4'd0;
      addr_q    <= '0;
      wd_q      <= 32'd0;
      ctrl_q    <= 3'd0;
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      pending_q <= 1'b0;
      presc_q   <= 16'd0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
      presc_q   <= presc_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_riscv_timer_slave.sv
// Bench for riscv_timer_slave: directed literal scenarios plus randomized bus traffic and
// irq_ret pulses, checked every cycle against a cycle-stamped behavioural model.
module tb_riscv_timer_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int LAT = 2;
  localparam int PRE = 1;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [3:0]  mem_be_i = 4'd0;
  logic [31:0] mem_addr_i = 32'd0;
  logic [31:0] mem_wd_i = 32'd0;
  logic [31:0] mem_rd_o;
  logic        mem_ready_o;
  logic        irq_req_o;
  logic        irq_ret_i = 1'b0;

  always #5 clk_i = ~clk_i;

  riscv_timer_slave #(.BASE_ADDR(BASE), .LATENCY(LAT), .PRESCALE(PRE)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_be_i(mem_be_i),
    .mem_addr_i(mem_addr_i), .mem_wd_i(mem_wd_i),
    .mem_rd_o(mem_rd_o), .mem_ready_o(mem_ready_o),
    .irq_req_o(irq_req_o), .irq_ret_i(irq_ret_i)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0]  m_ctrl;
  logic [31:0] m_count, m_compare;
  logic        m_pending, m_irq;
  int unsigned m_en_cycles;
  logic        m_busy, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wd;
  int          m_ready_at, cyc;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] w,
                                         input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return {29'd0, m_ctrl};
      2'd1:    return m_count;
      2'd2:    return m_compare;
      default: return {31'd0, m_pending};
    endcase
  endfunction

  logic        t_tick, t_match, t_commit, t_clr;
  logic [2:0]  n_ctrl;
  logic [31:0] n_count, n_compare;
  logic        n_pending, n_irq;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_ctrl = 3'd0; m_count = 32'd0; m_compare = 32'hFFFF_FFFF;
      m_pending = 1'b0; m_irq = 1'b0; m_en_cycles = 0;
      m_busy = 1'b0; m_we = 1'b0; m_be = 4'd0; m_addr = 32'd0; m_wd = 32'd0;
      m_ready_at = -1; cyc = 0;
    end else begin
      t_commit = m_busy && (cyc == m_ready_at);
      t_tick = 1'b0;
      if (m_ctrl[0]) begin
        m_en_cycles++;
        t_tick = (m_en_cycles % PRE) == 0;
      end
      t_match   = t_tick && (m_count == m_compare);
      n_irq     = m_pending && m_ctrl[2];
      n_ctrl    = m_ctrl;
      n_compare = m_compare;
      n_count   = m_count;
      if (t_tick) n_count = (t_match && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
      t_clr = irq_ret_i;
      if (t_commit && m_we && (m_addr[31:4] == BASE[31:4])) begin
        case (m_addr[3:2])
          2'd0:    if (m_be[0]) n_ctrl = m_wd[2:0];
          2'd1:    if (m_be != 4'd0) n_count = bmerge(m_count, m_wd, m_be);
          2'd2:    n_compare = bmerge(m_compare, m_wd, m_be);
          default: if (m_be[0] && m_wd[0]) t_clr = 1'b1;
        endcase
      end
      n_pending = t_match ? 1'b1 : (t_clr ? 1'b0 : m_pending);
      if (t_commit) begin
        m_busy = 1'b0;
      end else if (!m_busy && mem_req_i) begin
        m_busy = 1'b1; m_we = mem_we_i; m_be = mem_be_i;
        m_addr = mem_addr_i; m_wd = mem_wd_i;
        m_ready_at = cyc + LAT + 1;
      end
      m_ctrl = n_ctrl; m_count = n_count; m_compare = n_compare;
      m_pending = n_pending; m_irq = n_irq;
      cyc++;
    end
  end

  // ---------------- every-cycle compare ----------------
  logic exp_ready;
  always @(negedge clk_i) begin
    if (rst_ni) begin
      exp_ready = m_busy && (cyc == m_ready_at);
      check("ready", 32'(mem_ready_o), 32'(exp_ready));
      if (exp_ready && !m_we) check("rd", mem_rd_o, m_read(m_addr));
      check("irq", 32'(irq_req_o), 32'(m_irq));
    end
  end

  // ---------------- driver ----------------
  task automatic access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd);
    int n;
    @(negedge clk_i);
    mem_req_i = 1'b1; mem_we_i = we; mem_be_i = be; mem_addr_i = addr; mem_wd_i = wd;
    n = 0;
    rd = 32'd0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i);
      if (mem_ready_o) begin
        n = i;
        rd = mem_rd_o;
        break;
      end
    end
    mem_req_i = 1'b0;
    check("latency", 32'(n), 32'(LAT + 1));
  endtask

  logic ret_rand = 1'b0;
  always @(negedge clk_i) if (ret_rand) irq_ret_i = ($urandom_range(0, 7) == 0);

  logic [31:0] rd;
  int          k;
  logic [1:0]  r;
  logic [31:0] a, w;

  initial begin
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", 32'(mem_ready_o), 32'd0);
    check("rst_rd", mem_rd_o, 32'd0);
    check("rst_irq", 32'(irq_req_o), 32'd0);
    rst_ni = 1'b1;

    // reset value of COMPARE, single-cycle ready
    access(1'b0, 4'hF, BASE + 32'h8, 32'd0, rd);
    check("compare_reset", rd, 32'hFFFF_FFFF);
    @(negedge clk_i);
    check("ready_one_cycle", 32'(mem_ready_o), 32'd0);

    // partial and empty byte enables
    access(1'b1, 4'b0011, BASE + 32'h4, 32'h1234_5678, rd);
    access(1'b0, 4'hF, BASE + 32'h4, 32'd0, rd);
    check("count_be0011", rd, 32'h0000_5678);
    access(1'b1, 4'b0000, BASE + 32'h4, 32'hFFFF_FFFF, rd);
    access(1'b0, 4'hF, BASE + 32'h4, 32'd0, rd);
    check("count_be0000", rd, 32'h0000_5678);

    // auto-reload match and interrupt handshake
    access(1'b1, 4'hF, BASE + 32'h4, 32'd0, rd);
    access(1'b1, 4'hF, BASE + 32'h8, 32'd5, rd);
    access(1'b1, 4'hF, BASE + 32'h0, 32'd7, rd);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk_i);
      if (irq_req_o) begin k = i; break; end
    end
    check("irq_rise_delay", 32'(k), 32'd8);
    irq_ret_i = 1'b1;
    @(negedge clk_i);
    irq_ret_i = 1'b0;
    @(negedge clk_i);
    check("irq_after_ret", 32'(irq_req_o), 32'd0);
    access(1'b1, 4'hF, BASE + 32'h0, 32'd0, rd);
    access(1'b1, 4'hF, BASE + 32'hC, 32'd1, rd);

    // free-running wrap without auto-reload
    access(1'b1, 4'hF, BASE + 32'h4, 32'hFFFF_FFFE, rd);
    access(1'b1, 4'hF, BASE + 32'h8, 32'hFFFF_FFFF, rd);
    access(1'b1, 4'hF, BASE + 32'h0, 32'd1, rd);
    access(1'b0, 4'hF, BASE + 32'hC, 32'd0, rd);
    check("wrap_pending", rd, 32'd1);
    access(1'b0, 4'hF, BASE + 32'h4, 32'd0, rd);
    check("wrap_count", rd, 32'd5);

    // match coinciding with irq_ret: set wins
    access(1'b1, 4'hF, BASE + 32'h0, 32'd0, rd);
    access(1'b1, 4'hF, BASE + 32'h4, 32'd0, rd);
    access(1'b1, 4'hF, BASE + 32'h8, 32'd3, rd);
    access(1'b1, 4'hF, BASE + 32'hC, 32'd1, rd);
    access(1'b1, 4'hF, BASE + 32'h0, 32'd5, rd);
    repeat (4) @(negedge clk_i);
    irq_ret_i = 1'b1;
    @(negedge clk_i);
    irq_ret_i = 1'b0;
    access(1'b0, 4'hF, BASE + 32'hC, 32'd0, rd);
    check("set_beats_ret", rd, 32'd1);
    check("irq_held", 32'(irq_req_o), 32'd1);

    // IRQ_EN masks the request but keeps PENDING
    access(1'b1, 4'hF, BASE + 32'h0, 32'd1, rd);
    repeat (2) @(negedge clk_i);
    check("irq_masked", 32'(irq_req_o), 32'd0);
    access(1'b0, 4'hF, BASE + 32'hC, 32'd0, rd);
    check("pending_kept", rd, 32'd1);

    // COUNT write on a tick cycle wins
    access(1'b1, 4'hF, BASE + 32'h8, 32'hFFFF_0000, rd);
    access(1'b1, 4'hF, BASE + 32'h4, 32'hABCD_0000, rd);
    access(1'b0, 4'hF, BASE + 32'h4, 32'd0, rd);
    check("count_write_wins", rd, 32'hABCD_0003);

    // reset in the middle of a COMPARE write
    @(negedge clk_i);
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_be_i = 4'hF;
    mem_addr_i = BASE + 32'h8; mem_wd_i = 32'h0000_0011;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    mem_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (mem_ready_o) k++;
    end
    check("no_ready_after_rst", 32'(k), 32'd0);
    access(1'b0, 4'hF, BASE + 32'h8, 32'd0, rd);
    check("compare_aborted", rd, 32'hFFFF_FFFF);
    access(1'b0, 4'hF, BASE + 32'h40, 32'd0, rd);
    check("out_of_window", rd, 32'd0);

    // randomized traffic
    ret_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = BASE + 32'h10 + ($urandom_range(0, 255) << 4);
      else a = BASE + {28'd0, r, 2'($urandom_range(0, 3))};
      w = (r == 2'd0) ? 32'($urandom_range(0, 7)) :
          (r == 2'd3) ? 32'($urandom_range(0, 1)) : 32'($urandom_range(0, 24));
      if ($urandom_range(0, 15) == 0) w = $urandom;
      access($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), a, w, rd);
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
    end
    ret_rand = 1'b0;
    @(negedge clk_i);
    irq_ret_i = 1'b0;
    repeat (4) @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation did not complete, expected completion within budget");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
